axi_to_lite: RTL and testbench

Bridge that lets a full AXI master drive an AXI-Lite slave. Each AXI burst is split into single-beat AXI-Lite transactions. The block regenerates r_id, r_last and b_id, and merges per-beat write responses into a single B. Read and write paths are independent; each has at most one burst in flight. Address and data widths must match; no width conversion is performed.

---
 rtl/axi_to_lite_if.sv | 143 ++++++++++++++
 rtl/axi_to_lite.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_to_lite.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_to_lite_if.sv
// Bus interfaces for the AXI to AXI-Lite bridge: a full AXI channel bundle
// and an AXI-Lite channel bundle, each with master/slave views.

interface axi_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;

    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_prot, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_to_lite.sv
// AXI to AXI-Lite bridge: splits each AXI burst into single-beat lite
// transactions, regenerates r_id/r_last/b_id and merges write responses.

module axi_to_lite #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    axi_channel.slave       master,
    axi_lite_channel.master slave
);

    localparam int ID_W     = $bits(master.ar_id);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    if ($bits(master.aw_addr) != ADDR_WIDTH || $bits(slave.aw_addr) != ADDR_WIDTH) begin : g_addr_mismatch
        $fatal(1, "axi_to_lite: ADDR_WIDTH differs between interfaces");
    end
    if ($bits(master.w_data) != DATA_WIDTH || $bits(slave.w_data) != DATA_WIDTH) begin : g_data_mismatch
        $fatal(1, "axi_to_lite: DATA_WIDTH differs between interfaces");
    end

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BEAT, W_BRESP_LITE, W_BRESP} wr_state_t;

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        if (size > 3'(MAX_SIZE)) return 3'(MAX_SIZE);
        return size;
    endfunction

    // Reserved burst type and WRAP with an illegal length fall back to INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        logic                  wrap_ok;
        incr    = addr + (ADDR_WIDTH'(1) << size);
        mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        wrap_ok = (burst == 2'b10) &&
                  (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        if (burst == 2'b00) return addr;
        if (wrap_ok)        return (addr & ~mask) | (incr & mask);
        return incr;
    endfunction

    // Outputs stay quiet during reset and for one cycle after it.
    logic rst_q;
    logic hold;

    // Delayed reset used to extend the quiet window.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end
    assign hold = rst | rst_q;

    // ------------------------------------------------------------------ read
    rd_state_t             rd_state, rd_next;
    logic [ID_W-1:0]       rd_id;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len, rd_cnt;
    logic [2:0]            rd_size, rd_prot;
    logic [1:0]            rd_burst;
    logic                  ar_hs, lite_ar_hs, r_hs, rd_last;

    assign ar_hs      = master.ar_valid && master.ar_ready;
    assign lite_ar_hs = slave.ar_valid && slave.ar_ready;
    assign r_hs       = master.r_valid && master.r_ready;
    assign rd_last    = (rd_cnt == rd_len);

    assign slave.ar_addr = rd_addr;
    assign slave.ar_prot = rd_prot;
    assign master.r_id   = rd_id;
    assign master.r_data = slave.r_data;
    assign master.r_resp = slave.r_resp;
    assign master.r_last = rd_last;
    assign master.r_user = '0;

    // Read state register.
    always_ff @(posedge clk) begin
        if (rst) rd_state <= R_IDLE;
        else     rd_state <= rd_next;
    end

    // Read next-state logic.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs)      rd_next = R_ADDR;
            R_ADDR:  if (lite_ar_hs) rd_next = R_DATA;
            R_DATA:  if (r_hs)       rd_next = rd_last ? R_IDLE : R_ADDR;
            default:                 rd_next = R_IDLE;
        endcase
    end

    // Read handshake outputs; R data is a straight pass-through in DATA.
    always_comb begin
        master.ar_ready = 1'b0;
        slave.ar_valid  = 1'b0;
        master.r_valid  = 1'b0;
        slave.r_ready   = 1'b0;
        if (!hold) begin
            case (rd_state)
                R_IDLE: master.ar_ready = 1'b1;
                R_ADDR: slave.ar_valid  = 1'b1;
                R_DATA: begin
                    master.r_valid = slave.r_valid;
                    slave.r_ready  = master.r_ready;
                end
                default: ;
            endcase
        end
    end

    // Read burst registers and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_id    <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
            rd_size  <= '0;
            rd_prot  <= '0;
            rd_burst <= '0;
        end else if (ar_hs) begin
            rd_id    <= master.ar_id;
            rd_addr  <= master.ar_addr;
            rd_len   <= master.ar_len;
            rd_cnt   <= '0;
            rd_size  <= clamp_size(master.ar_size);
            rd_prot  <= master.ar_prot;
            rd_burst <= master.ar_burst;
        end else if (r_hs && !rd_last) begin
            rd_cnt  <= rd_cnt + 8'd1;
            rd_addr <= next_addr(rd_addr, rd_len, rd_size, rd_burst);
        end
    end

    // ----------------------------------------------------------------- write
    wr_state_t             wr_state, wr_next;
    logic [ID_W-1:0]       wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len, wr_cnt;
    logic [2:0]            wr_size, wr_prot;
    logic [1:0]            wr_burst, acc_resp, merged_resp;
    logic                  aw_done, w_done;
    logic                  aw_hs, lite_aw_hs, lite_w_hs, lite_b_hs, b_hs, beat_done, wr_last;

    assign aw_hs       = master.aw_valid && master.aw_ready;
    assign lite_aw_hs  = slave.aw_valid && slave.aw_ready;
    assign lite_w_hs   = slave.w_valid && slave.w_ready;
    assign lite_b_hs   = slave.b_valid && slave.b_ready;
    assign b_hs        = master.b_valid && master.b_ready;
    assign beat_done   = (aw_done || lite_aw_hs) && (w_done || lite_w_hs);
    assign wr_last     = (wr_cnt == wr_len);
    assign merged_resp = (slave.b_resp > acc_resp) ? slave.b_resp : acc_resp;

    assign slave.aw_addr = wr_addr;
    assign slave.aw_prot = wr_prot;
    assign slave.w_data  = master.w_data;
    assign slave.w_strb  = master.w_strb;
    assign master.b_id   = wr_id;
    assign master.b_resp = acc_resp;
    assign master.b_user = '0;

    // Write state register.
    always_ff @(posedge clk) begin
        if (rst) wr_state <= W_IDLE;
        else     wr_state <= wr_next;
    end

    // Write next-state logic.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:       if (aw_hs)     wr_next = W_BEAT;
            W_BEAT:       if (beat_done) wr_next = W_BRESP_LITE;
            W_BRESP_LITE: if (lite_b_hs) wr_next = wr_last ? W_BRESP : W_BEAT;
            W_BRESP:      if (b_hs)      wr_next = W_IDLE;
            default:                     wr_next = W_IDLE;
        endcase
    end

    // Write handshake outputs; lite AW and W are independent within a beat.
    always_comb begin
        master.aw_ready = 1'b0;
        slave.aw_valid  = 1'b0;
        slave.w_valid   = 1'b0;
        master.w_ready  = 1'b0;
        slave.b_ready   = 1'b0;
        master.b_valid  = 1'b0;
        if (!hold) begin
            case (wr_state)
                W_IDLE: master.aw_ready = 1'b1;
                W_BEAT: begin
                    slave.aw_valid = !aw_done;
                    slave.w_valid  = master.w_valid && !w_done;
                    master.w_ready = slave.w_ready && !w_done;
                end
                W_BRESP_LITE: slave.b_ready  = 1'b1;
                W_BRESP:      master.b_valid = 1'b1;
                default: ;
            endcase
        end
    end

    // Write burst registers, per-beat done flags and response accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_id    <= '0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
            wr_size  <= '0;
            wr_prot  <= '0;
            wr_burst <= '0;
            acc_resp <= 2'b00;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (aw_hs) begin
            wr_id    <= master.aw_id;
            wr_addr  <= master.aw_addr;
            wr_len   <= master.aw_len;
            wr_cnt   <= '0;
            wr_size  <= clamp_size(master.aw_size);
            wr_prot  <= master.aw_prot;
            wr_burst <= master.aw_burst;
            acc_resp <= 2'b00;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (wr_state == W_BEAT) begin
            if (beat_done) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (lite_aw_hs) aw_done <= 1'b1;
                if (lite_w_hs)  w_done  <= 1'b1;
            end
        end else if (lite_b_hs) begin
            acc_resp <= merged_resp;
            if (!wr_last) begin
                wr_cnt  <= wr_cnt + 8'd1;
                wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst);
            end
        end
    end

    // Fields the bridge deliberately ignores.
    logic unused;
    assign unused = &{1'b0, master.aw_lock, master.aw_cache, master.aw_qos,
                      master.aw_region, master.aw_user, master.ar_lock,
                      master.ar_cache, master.ar_qos, master.ar_region,
                      master.ar_user, master.w_last, master.w_user};

endmodule

// File: tb/tb_axi_to_lite.sv
// Directed scoreboard bench for axi_to_lite with a reactive AXI-Lite slave.

module tb_axi_to_lite;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   aw_late = 0;

    always #5 clk = ~clk;

    axi_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1)) m_if ();
    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) l_if ();

    axi_to_lite #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .master (m_if.slave),
        .slave  (l_if.master)
    );

    typedef struct {logic [63:0] data; logic [7:0] strb;} wexp_t;
    typedef struct {logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rexp_t;
    typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;

    logic [47:0] exp_ar_q[$];
    logic [47:0] exp_aw_q[$];
    wexp_t       exp_w_q[$];
    rexp_t       exp_r_q[$];
    bexp_t       exp_b_q[$];
    logic [1:0]  bresp_q[$];

    function automatic logic [63:0] lite_data(input logic [47:0] addr);
        return {16'hD00D, addr};
    endfunction

    function automatic logic [1:0] lite_rresp(input logic [47:0] addr);
        return (addr == 48'h40) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [9:0] ctl_vec();
        return {m_if.aw_ready, m_if.ar_ready, m_if.w_ready, m_if.r_valid, m_if.b_valid,
                l_if.aw_valid, l_if.ar_valid, l_if.w_valid, l_if.r_ready, l_if.b_ready};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout waiting for handshake", tag);
    endtask

    // Overall guard so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reactive AXI-Lite slave; checks every lite request against the scoreboard.
    initial begin : lite_slave
        logic        r_busy, aw_got, w_got, b_busy;
        logic [47:0] r_addr;
        int          aw_age;
        wexp_t       we;
        r_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_busy = 1'b0;
        r_addr = '0;   aw_age = 0;
        forever begin
            @(negedge clk);
            l_if.ar_ready = !r_busy;
            l_if.r_valid  = r_busy;
            l_if.r_data   = r_busy ? lite_data(r_addr) : 64'h0;
            l_if.r_resp   = r_busy ? lite_rresp(r_addr) : 2'b00;
            l_if.aw_ready = (aw_age >= aw_late) && !aw_got;
            l_if.w_ready  = !w_got;
            l_if.b_valid  = b_busy;
            l_if.b_resp   = (b_busy && bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
            #4;
            if (rst) begin
                r_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_busy = 1'b0; aw_age = 0;
                continue;
            end
            if (l_if.ar_valid && l_if.ar_ready) begin
                check("lite_ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
                if (exp_ar_q.size() != 0) check("lite_ar_addr", l_if.ar_addr, exp_ar_q.pop_front());
                check("lite_ar_prot", l_if.ar_prot, 3'b010);
                r_busy = 1'b1;
                r_addr = l_if.ar_addr;
            end
            if (l_if.r_valid && l_if.r_ready) r_busy = 1'b0;
            if (l_if.aw_valid && !l_if.aw_ready) aw_age++;
            if (l_if.aw_valid && l_if.aw_ready) begin
                check("lite_aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
                if (exp_aw_q.size() != 0) check("lite_aw_addr", l_if.aw_addr, exp_aw_q.pop_front());
                check("lite_aw_prot", l_if.aw_prot, 3'b001);
                aw_got = 1'b1;
                aw_age = 0;
            end
            if (l_if.w_valid && l_if.w_ready) begin
                check("lite_w_expected", 64'(exp_w_q.size() != 0), 64'd1);
                if (exp_w_q.size() != 0) begin
                    we = exp_w_q.pop_front();
                    check("lite_w_data", l_if.w_data, we.data);
                    check("lite_w_strb", l_if.w_strb, we.strb);
                end
                w_got = 1'b1;
            end
            if (l_if.b_valid && l_if.b_ready) begin
                b_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                if (bresp_q.size() != 0) void'(bresp_q.pop_front());
            end else if (aw_got && w_got) begin
                b_busy = 1'b1;
            end
        end
    end

    // All master-side tasks start and end just after a falling edge.
    task automatic send_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        m_if.ar_id = id; m_if.ar_addr = addr; m_if.ar_len = len; m_if.ar_size = size;
        m_if.ar_burst = burst; m_if.ar_prot = 3'b010; m_if.ar_valid = 1'b1;
        for (int t = 0; ; t++) begin
            #4;
            if (m_if.ar_ready) break;
            if (t >= 100) begin timeout("ar"); break; end
            @(negedge clk);
        end
        @(negedge clk);
        m_if.ar_valid = 1'b0;
    endtask

    task automatic recv_r(input logic [7:0] len, input int rdelay);
        rexp_t re;
        for (int b = 0; b <= int'(len); b++) begin
            m_if.r_ready = 1'b0;
            repeat (rdelay) @(negedge clk);
            m_if.r_ready = 1'b1;
            for (int t = 0; ; t++) begin
                #4;
                if (m_if.r_valid) break;
                if (t >= 100) begin timeout("r"); m_if.r_ready = 1'b0; return; end
                @(negedge clk);
            end
            check("r_expected", 64'(exp_r_q.size() != 0), 64'd1);
            if (exp_r_q.size() != 0) begin
                re = exp_r_q.pop_front();
                check("r_data", m_if.r_data, re.data);
                check("r_resp", m_if.r_resp, re.resp);
                check("r_last", m_if.r_last, re.last);
                check("r_id", m_if.r_id, re.id);
            end
            @(negedge clk);
        end
        m_if.r_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int rdelay);
        send_ar(id, addr, len, size, burst);
        recv_r(len, rdelay);
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        m_if.aw_id = id; m_if.aw_addr = addr; m_if.aw_len = len; m_if.aw_size = size;
        m_if.aw_burst = burst; m_if.aw_prot = 3'b001; m_if.aw_valid = 1'b1;
        for (int t = 0; ; t++) begin
            #4;
            if (m_if.aw_ready) break;
            if (t >= 100) begin timeout("aw"); break; end
            @(negedge clk);
        end
        @(negedge clk);
        m_if.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        wexp_t we;
        we.data = data; we.strb = strb;
        exp_w_q.push_back(we);
        m_if.w_data = data; m_if.w_strb = strb; m_if.w_last = last; m_if.w_valid = 1'b1;
        for (int t = 0; ; t++) begin
            #4;
            if (m_if.w_ready) break;
            if (t >= 100) begin timeout("w"); break; end
            @(negedge clk);
        end
        @(negedge clk);
        m_if.w_valid = 1'b0;
    endtask

    task automatic recv_b();
        bexp_t be;
        m_if.b_ready = 1'b1;
        for (int t = 0; ; t++) begin
            #4;
            if (m_if.b_valid) break;
            if (t >= 200) begin timeout("b"); m_if.b_ready = 1'b0; return; end
            @(negedge clk);
        end
        check("b_expected", 64'(exp_b_q.size() != 0), 64'd1);
        if (exp_b_q.size() != 0) begin
            be = exp_b_q.pop_front();
            check("b_id", m_if.b_id, be.id);
            check("b_resp", m_if.b_resp, be.resp);
        end
        @(negedge clk);
        m_if.b_ready = 1'b0;
        #4;
        check("b_single", m_if.b_valid, 1'b0);
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [63:0] seed, input logic [7:0] strb);
        send_aw(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) send_w(seed + 64'(b), strb, b == int'(len));
        recv_b();
    endtask

    task automatic push_r(input logic [47:0] addr, input logic last, input logic [3:0] id);
        rexp_t re;
        re.data = lite_data(addr); re.resp = lite_rresp(addr); re.last = last; re.id = id;
        exp_ar_q.push_back(addr);
        exp_r_q.push_back(re);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        bexp_t be;
        be.id = id; be.resp = resp;
        exp_b_q.push_back(be);
    endtask

    initial begin
        rst = 1'b1;
        m_if.aw_valid = 1'b0; m_if.w_valid = 1'b0; m_if.b_ready = 1'b0;
        m_if.ar_valid = 1'b0; m_if.r_ready = 1'b0;
        m_if.aw_id = '0; m_if.aw_addr = '0; m_if.aw_len = '0; m_if.aw_size = '0;
        m_if.aw_burst = '0; m_if.aw_lock = 1'b0; m_if.aw_cache = '0; m_if.aw_prot = '0;
        m_if.aw_qos = '0; m_if.aw_region = '0; m_if.aw_user = '0;
        m_if.ar_id = '0; m_if.ar_addr = '0; m_if.ar_len = '0; m_if.ar_size = '0;
        m_if.ar_burst = '0; m_if.ar_lock = 1'b0; m_if.ar_cache = '0; m_if.ar_prot = '0;
        m_if.ar_qos = '0; m_if.ar_region = '0; m_if.ar_user = '0;
        m_if.w_data = '0; m_if.w_strb = '0; m_if.w_last = 1'b0; m_if.w_user = '0;

        // Reset: everything quiet during reset and in the cycle after.
        @(negedge clk);
        @(negedge clk); #4;
        check("reset_ctl", ctl_vec(), 10'b0);
        @(negedge clk); rst = 1'b0; #4;
        check("reset_after_ctl", ctl_vec(), 10'b0);
        @(negedge clk); #4;
        check("idle_readies", {m_if.aw_ready, m_if.ar_ready}, 2'b11);
        @(negedge clk);

        // Single read, SLVERR passed through.
        push_r(48'h40, 1'b1, 4'h3);
        axi_read(4'h3, 48'h40, 8'd0, 3'd3, 2'b01, 0);

        // INCR write of four beats.
        exp_aw_q.push_back(48'h1000); exp_aw_q.push_back(48'h1008);
        exp_aw_q.push_back(48'h1010); exp_aw_q.push_back(48'h1018);
        push_b(4'h6, 2'b00);
        axi_write(4'h6, 48'h1000, 8'd3, 3'd3, 2'b01, 64'h1111_2222_3333_0000, 8'hF0);

        // WRAP read crossing the wrap boundary.
        push_r(48'h1010, 1'b0, 4'h2); push_r(48'h1018, 1'b0, 4'h2);
        push_r(48'h1000, 1'b0, 4'h2); push_r(48'h1008, 1'b1, 4'h2);
        axi_read(4'h2, 48'h1010, 8'd3, 3'd3, 2'b10, 0);

        // WRAP with len=2 behaves as INCR.
        push_r(48'h1010, 1'b0, 4'h1); push_r(48'h1018, 1'b0, 4'h1); push_r(48'h1020, 1'b1, 4'h1);
        axi_read(4'h1, 48'h1010, 8'd2, 3'd3, 2'b10, 0);

        // Oversized size clamps to 8-byte steps.
        push_r(48'h500, 1'b0, 4'h4); push_r(48'h508, 1'b1, 4'h4);
        axi_read(4'h4, 48'h500, 8'd1, 3'd5, 2'b01, 0);

        // Response merge: worst response wins.
        exp_aw_q.push_back(48'h2000); exp_aw_q.push_back(48'h2008);
        exp_aw_q.push_back(48'h2010); exp_aw_q.push_back(48'h2018);
        bresp_q.push_back(2'b00); bresp_q.push_back(2'b10);
        bresp_q.push_back(2'b00); bresp_q.push_back(2'b11);
        push_b(4'hA, 2'b11);
        axi_write(4'hA, 48'h2000, 8'd3, 3'd3, 2'b01, 64'hAAAA_0000_0000_0000, 8'hFF);

        // Backpressure: FIXED read with slow r_ready alongside a write with late lite aw_ready.
        push_r(48'h80, 1'b0, 4'h5); push_r(48'h80, 1'b0, 4'h5); push_r(48'h80, 1'b1, 4'h5);
        exp_aw_q.push_back(48'h3000); exp_aw_q.push_back(48'h3004);
        push_b(4'hC, 2'b00);
        aw_late = 3;
        fork
            axi_read(4'h5, 48'h80, 8'd2, 3'd3, 2'b00, 5);
            axi_write(4'hC, 48'h3000, 8'd1, 3'd2, 2'b01, 64'h0000_0000_CCCC_0000, 8'h0F);
        join
        aw_late = 0;

        // Reset during beat 2 of a 4-beat write.
        exp_aw_q.push_back(48'h4000); exp_aw_q.push_back(48'h4008);
        send_aw(4'h7, 48'h4000, 8'd3, 3'd3, 2'b01);
        send_w(64'h7777_0000_0000_0000, 8'hFF, 1'b0);
        send_w(64'h7777_0000_0000_0001, 8'hFF, 1'b0);
        rst = 1'b1; #4;
        check("rst_mid_ctl", ctl_vec(), 10'b0);
        @(negedge clk); rst = 1'b0; #4;
        check("rst_mid_after_ctl", ctl_vec(), 10'b0);
        exp_aw_q.delete(); exp_w_q.delete(); bresp_q.delete(); exp_b_q.delete();
        @(negedge clk);
        exp_aw_q.push_back(48'h5000);
        push_b(4'h9, 2'b00);
        axi_write(4'h9, 48'h5000, 8'd0, 3'd3, 2'b01, 64'h9999_0000_0000_0000, 8'h3C);

        // Nothing left outstanding.
        repeat (3) @(negedge clk);
        check("ar_q_drained", 64'(exp_ar_q.size()), 64'd0);
        check("aw_q_drained", 64'(exp_aw_q.size()), 64'd0);
        check("r_q_drained", 64'(exp_r_q.size()), 64'd0);
        check("b_q_drained", 64'(exp_b_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
